// File: rtl/uart_rx_fsm.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fsm
// Description : 8N1 UART receiver with a 2-flop input synchronizer and a
//               mid-bit sampling FSM. Optional majority-vote sampling is
//               enabled by defining UART_RX_VOTE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fsm #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int c_CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [c_CNT_W-1:0] c_BIT_M1 = c_CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t             r_state;
    logic               r_sync1;
    logic               r_rx_s;
    logic               r_rx_d;
    logic [c_CNT_W-1:0] r_cnt;
    logic [2:0]         r_bit_idx;
    logic [7:0]         r_shift;
    logic [7:0]         r_rx_data;
    logic               r_rx_valid;
    logic               r_frame_err;
    logic               r_busy;
    logic               w_sample;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_rx_s  <= 1'b1;
            r_rx_d  <= 1'b1;
        end else begin
            r_sync1 <= rx_in;
            r_rx_s  <= r_sync1;
            r_rx_d  <= r_rx_s;
        end
    end

`ifdef UART_RX_VOTE_EN
    // Decision point moves one clock later so the three votes straddle mid-bit.
    localparam logic [c_CNT_W-1:0] c_START_PT = c_CNT_W'(CLKS_PER_BIT / 2);

    logic [1:0] r_hist;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hist <= 2'b11;
        end else begin
            r_hist <= {r_hist[0], r_rx_s};
        end
    end

    assign w_sample = (r_hist[1] & r_hist[0]) | (r_hist[1] & r_rx_s) | (r_hist[0] & r_rx_s);
`else
    localparam logic [c_CNT_W-1:0] c_START_PT = c_CNT_W'(CLKS_PER_BIT / 2 - 1);

    assign w_sample = r_rx_s;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= 3'd0;
            r_shift     <= 8'h00;
            r_rx_data   <= 8'h00;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cnt     <= '0;
                    r_bit_idx <= 3'd0;
                    // Only a fresh high-to-low transition starts a frame.
                    if (r_rx_d && !r_rx_s) begin
                        r_state <= S_START;
                        r_busy  <= 1'b1;
                    end
                end
                S_START: begin
                    if (r_cnt == c_START_PT) begin
                        r_cnt <= '0;
                        if (!w_sample) begin
                            r_state <= S_DATA;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (r_cnt == c_BIT_M1) begin
                        r_cnt     <= '0;
                        r_shift   <= {w_sample, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= S_STOP;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (r_cnt == c_BIT_M1) begin
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        if (w_sample) begin
                            r_rx_data  <= r_shift;
                            r_rx_valid <= 1'b1;
                        end else begin
                            r_frame_err <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign frame_err = r_frame_err;
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_fsm
// Description : Directed, table-driven bench for uart_rx_fsm (16 clks/bit).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fsm;

    localparam int CLKS = 16;
    localparam int MID  = CLKS / 2;
`ifdef UART_RX_VOTE_EN
    localparam int c_VOTE = 1;
`else
    localparam int c_VOTE = 0;
`endif
    // Line driven just after edge E0; stop-bit decision lands on E(3+MID+9*CLKS).
    localparam int c_LAT = 3 + MID + 9 * CLKS + c_VOTE;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_in;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;

    always #5 clk = ~clk;

    uart_rx_fsm #(.CLKS_PER_BIT(CLKS)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_in     (rx_in),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    int n_checks  = 0;
    int n_fail    = 0;
    int cyc       = 0;
    int t0        = 0;
    int valid_cyc = 0;
    int ferr_cyc  = 0;
    int busy_cyc  = 0;
    int both_cyc  = 0;
    int last_lat  = -1;
    logic [7:0] rxq[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_valid) begin
            valid_cyc++;
            last_lat = cyc - t0;
            rxq.push_back(rx_data);
        end
        if (frame_err) ferr_cyc++;
        if (busy) busy_cyc++;
        if (rx_valid && frame_err) both_cyc++;
    end

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         exp_valid;
        int         exp_ferr;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx_in = 1'b1;
        for (int i = 0; i < n; i++) tick();
    endtask

    // Drives the first ncyc clocks of a frame; glitch forces the line high for one clock.
    task automatic send_bits(input logic [7:0] d, input logic stop, input int glitch, input int ncyc);
        logic [9:0] bits;
        bits = {stop, d, 1'b0};
        t0   = cyc;
        for (int i = 0; i < ncyc; i++) begin
            rx_in = bits[i / CLKS];
            if (i == glitch) rx_in = 1'b1;
            tick();
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        send_bits(d, stop, -1, 10 * CLKS);
    endtask

    int v0, f0, b0, q0;

    initial begin
        vecs[0] = '{8'h55, 1'b1, 1, 0, 8'h55};
        vecs[1] = '{8'hAA, 1'b1, 1, 0, 8'hAA};
        vecs[2] = '{8'h3C, 1'b0, 0, 1, 8'hAA};
        vecs[3] = '{8'hFF, 1'b1, 1, 0, 8'hFF};
        vecs[4] = '{8'h00, 1'b0, 0, 1, 8'hFF};
        vecs[5] = '{8'h01, 1'b1, 1, 0, 8'h01};
        vecs[6] = '{8'h80, 1'b1, 1, 0, 8'h80};

        rst   = 1'b1;
        rx_in = 1'b1;
        tick();
        tick();
        tick();
        check("reset_rx_data", rx_data, 8'h00);
        check("reset_rx_valid", rx_valid, 0);
        check("reset_frame_err", frame_err, 0);
        check("reset_busy", busy, 0);
        rst = 1'b0;
        idle(10);

        for (int k = 0; k < 7; k++) begin
            v0 = valid_cyc;
            f0 = ferr_cyc;
            send_frame(vecs[k].data, vecs[k].stop);
            idle(8);
            check($sformatf("vec%0d_valid_cycles", k), valid_cyc - v0, vecs[k].exp_valid);
            check($sformatf("vec%0d_ferr_cycles", k), ferr_cyc - f0, vecs[k].exp_ferr);
            check($sformatf("vec%0d_rx_data", k), rx_data, vecs[k].exp_data);
            check($sformatf("vec%0d_busy_idle", k), busy, 0);
            if (vecs[k].exp_valid == 1) check($sformatf("vec%0d_latency", k), last_lat, c_LAT);
        end

        // Back-to-back frames with no idle gap.
        v0 = valid_cyc;
        q0 = rxq.size();
        send_frame(8'hAA, 1'b1);
        send_frame(8'hF0, 1'b1);
        idle(8);
        check("b2b_valid_cycles", valid_cyc - v0, 2);
        if (rxq.size() >= q0 + 2) begin
            check("b2b_first", rxq[q0], 8'hAA);
            check("b2b_second", rxq[q0+1], 8'hF0);
        end else begin
            check("b2b_queue_len", rxq.size() - q0, 2);
        end

        // Bad stop bit keeps the previous byte.
        v0 = valid_cyc;
        f0 = ferr_cyc;
        send_frame(8'h3C, 1'b0);
        idle(8);
        check("badstop_ferr_cycles", ferr_cyc - f0, 1);
        check("badstop_valid_cycles", valid_cyc - v0, 0);
        check("badstop_rx_data", rx_data, 8'hF0);

        // False start: 4-clock low pulse.
        v0 = valid_cyc;
        f0 = ferr_cyc;
        b0 = busy_cyc;
        rx_in = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        idle(20);
        n_checks++;
        if (busy_cyc - b0 < 1 || busy_cyc - b0 > 9) begin
            n_fail++;
            $display("FAIL false_start_busy_len: got %0d cycles expected 1..9", busy_cyc - b0);
        end
        check("false_start_valid", valid_cyc - v0, 0);
        check("false_start_ferr", ferr_cyc - f0, 0);
        check("false_start_busy_end", busy, 0);

        // Reset in the middle of data bit 4 of 0x81.
        v0 = valid_cyc;
        f0 = ferr_cyc;
        send_bits(8'h81, 1'b1, -1, 5 * CLKS + MID);
        check("midframe_busy_before_rst", busy, 1);
        rst   = 1'b1;
        rx_in = 1'b1;
        tick();
        check("midrst_rx_data", rx_data, 8'h00);
        check("midrst_busy", busy, 0);
        check("midrst_rx_valid", rx_valid, 0);
        rst = 1'b0;
        idle(40);
        check("midrst_no_valid", valid_cyc - v0, 0);
        check("midrst_no_ferr", ferr_cyc - f0, 0);
        v0 = valid_cyc;
        send_frame(8'h81, 1'b1);
        idle(8);
        check("after_rst_valid", valid_cyc - v0, 1);
        check("after_rst_rx_data", rx_data, 8'h81);

        // One-clock high glitch at the middle of data bit 0 of 0x00.
        v0 = valid_cyc;
        send_bits(8'h00, 1'b1, MID + CLKS, 10 * CLKS);
        idle(8);
        check("glitch_valid", valid_cyc - v0, 1);
        check("glitch_rx_data", rx_data, (c_VOTE == 1) ? 8'h00 : 8'h01);

        check("valid_ferr_overlap", both_cyc, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
